lif_neuron_array: RTL
=====================

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4, number of independent neuron channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 8, membrane and input-current width in bits (4..16).
REQ-003 SHALL have parameter REFRACT, default 3, refractory length in steps after a spike (0..255).
REQ-004 SHALL have parameter THR_DEFAULT, default 100, threshold value at reset.
REQ-005 SHALL have parameter LEAK_DEFAULT, default 2, leak shift value at reset.
REQ-006 SHALL have one clock and an asynchronous, active-low reset, with ports as below.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port ena, input, 1, step enable; each rising edge with ena=1 is one integration step.
REQ-010 SHALL have port cur_in, input, N_NEURONS*WIDTH, unsigned currents; channel i at bits [i*WIDTH +: WIDTH].
REQ-011 SHALL have port thr_in, input, WIDTH, new threshold value.
REQ-012 SHALL have port leak_in, input, 3, new leak shift value.
REQ-013 SHALL have port cfg_we, input, 1, loads thr_in and leak_in.
REQ-014 SHALL have port vmem_sel, input, clog2(N_NEURONS) (minimum 1), membrane readout select.
REQ-015 SHALL have port vmem_out, output, WIDTH, membrane of the selected channel.
REQ-016 SHALL have port spike_out, output, N_NEURONS, registered one-step spike pulses.
REQ-017 SHALL have port spike_any, output, 1, registered OR of spike_out.
REQ-018 SHALL have port refr_busy, output, N_NEURONS, channel refractory counter nonzero.

Function
REQ-019 cfg_we=1 at an edge SHALL register thr and leak; any step at that same edge SHALL use the old values.
REQ-020 For each non-refractory channel, a step SHALL compute sum = V - (V >> leak) + cur_i, using WIDTH+1-bit unsigned arithmetic and saturating at 2^WIDTH-1.
REQ-021 If sum >= thr, the step SHALL set spike_out[i]=1, set V=0 and load the refractory counter with REFRACT; otherwise it SHALL set V=sum and spike_out[i]=0.
REQ-022 For a refractory channel, a step SHALL hold V=0, decrement the counter, drive spike_out[i]=0 and ignore cur_i.
REQ-023 With REFRACT=0, a channel SHALL never enter refractory, so it may spike on consecutive steps.
REQ-024 With thr=0, every non-refractory step SHALL spike.
REQ-025 An edge with ena=0 SHALL hold V and the counters and clear spike_out and spike_any to 0.
REQ-026 spike_any SHALL be registered alongside spike_out, with identical timing.
REQ-027 vmem_out SHALL be a combinational mux of the registered V; a vmem_sel of N_NEURONS or more SHALL give 0.
REQ-028 All channels SHALL update in parallel with a latency of one cycle from the step edge to spike_out and V.

Reset
REQ-029 rst_n=0 SHALL immediately clear all V, counters, spike_out, spike_any and refr_busy to 0, and set thr=THR_DEFAULT and leak=LEAK_DEFAULT.
REQ-030 Reset mid-refractory SHALL abort the refractory period; the first step after release integrates normally.

Structure
REQ-031 Package neuron_pkg SHALL hold the default constants, LEAK_W=3 and the refractory counter width of 8.
REQ-032 The per-channel integrate, threshold and refractory logic SHALL be sub-module lif_neuron_cell, instantiated N_NEURONS times by a generate loop; config registers and the readout mux SHALL stay in the top level.

Verification
REQ-033 Bench SHALL cover: thr=100, leak=2, cur0=30 held, ena=1 -> V0 goes 30,53,70,83,93; spike_out[0]=1 on step 6; V0 stays 0 for steps 7-9; V0=30 at step 10.
REQ-034 Bench SHALL cover: thr=255, leak=7, cur0=200 -> V0=200 after step 1; step 2 saturates to 255 and spikes.
REQ-035 Bench SHALL cover: V0=70, then ena=0 for 5 cycles -> V0 stays 70, spike_out=0, refr_busy unchanged.
REQ-036 Bench SHALL cover: rst_n pulsed low during refractory (refr_busy[0]=1) -> refr_busy=0, V=0 and thr=100 immediately; the next step gives V0=cur0.
REQ-037 Bench SHALL cover: cfg_we with thr_in=50 on the same edge as a step where sum=60 and old thr=100 -> no spike; the next step with sum>=50 spikes.
REQ-038 Bench SHALL cover: N_NEURONS=4 with distinct currents 0/10/50/255 and REFRACT=0 -> independent spike trains; ch3 spikes every step; spike_any is the OR of all channels.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared constants for the leaky integrate-and-fire neuron array.
package neuron_pkg;

  localparam int THR_DEFAULT_C     = 100;
  localparam int LEAK_DEFAULT_C    = 2;
  localparam int REFRACT_DEFAULT_C = 3;
  localparam int LEAK_W            = 3;
  localparam int RCNT_W            = 8;

  // Readout select width; a single-channel array still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lif_neuron_cell.sv
// One LIF channel: leak, integrate with saturation, threshold, refractory hold.
module lif_neuron_cell
  import neuron_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REFRACT = REFRACT_DEFAULT_C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [WIDTH-1:0]  cur_i,
  input  logic [WIDTH-1:0]  thr_i,
  input  logic [LEAK_W-1:0] leak_i,
  output logic [WIDTH-1:0]  vmem_o,
  output logic              spike_o,
  output logic              fire_o,
  output logic              busy_o
);

  localparam logic [RCNT_W-1:0] REFRACT_C = RCNT_W'(REFRACT);

  logic [WIDTH-1:0]  v_q, v_d;
  logic [RCNT_W-1:0] cnt_q, cnt_d;
  logic              spike_q, spike_d;
  logic [WIDTH-1:0]  sum;

  // Leaked membrane plus input, one extra bit of headroom, clamped to full scale.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0]  v,
                                               input logic [LEAK_W-1:0] sh,
                                               input logic [WIDTH-1:0]  cur);
    logic [WIDTH-1:0] leaked;
    logic [WIDTH:0]   s;
    leaked = v - (v >> sh);
    s      = {1'b0, leaked} + {1'b0, cur};
    return s[WIDTH] ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  // Next-state for one integration step; a disabled edge holds state and drops the pulse.
  always_comb begin
    v_d     = v_q;
    cnt_d   = cnt_q;
    spike_d = 1'b0;
    sum     = sat_sum(v_q, leak_i, cur_i);
    if (ena) begin
      if (cnt_q != '0) begin
        v_d   = '0;
        cnt_d = cnt_q - RCNT_W'(1);
      end else if (sum >= thr_i) begin
        spike_d = 1'b1;
        v_d     = '0;
        cnt_d   = REFRACT_C;
      end else begin
        v_d = sum;
      end
    end
  end

  // Membrane, refractory counter and spike pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      cnt_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      spike_q <= spike_d;
    end
  end

  assign vmem_o  = v_q;
  assign spike_o = spike_q;
  assign fire_o  = spike_d;
  assign busy_o  = (cnt_q != '0);

endmodule

// File: rtl/lif_neuron_array.sv
// Array of independent LIF channels with shared threshold/leak config and membrane readout.
module lif_neuron_array
  import neuron_pkg::*;
#(
  parameter int N_NEURONS    = 4,
  parameter int WIDTH        = 8,
  parameter int REFRACT      = REFRACT_DEFAULT_C,
  parameter int THR_DEFAULT  = THR_DEFAULT_C,
  parameter int LEAK_DEFAULT = LEAK_DEFAULT_C
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic [N_NEURONS*WIDTH-1:0]      cur_in,
  input  logic [WIDTH-1:0]                thr_in,
  input  logic [LEAK_W-1:0]               leak_in,
  input  logic                            cfg_we,
  input  logic [sel_width(N_NEURONS)-1:0] vmem_sel,
  output logic [WIDTH-1:0]                vmem_out,
  output logic [N_NEURONS-1:0]            spike_out,
  output logic                            spike_any,
  output logic [N_NEURONS-1:0]            refr_busy
);

  localparam int SEL_W = sel_width(N_NEURONS);

  logic [WIDTH-1:0]     thr_q;
  logic [LEAK_W-1:0]    leak_q;
  logic                 spike_any_q;
  logic [N_NEURONS-1:0] fire_w;
  logic [WIDTH-1:0]     vmem_w [N_NEURONS];

  // Config registers; a step on the load edge still sees the previous values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q  <= WIDTH'(THR_DEFAULT);
      leak_q <= LEAK_W'(LEAK_DEFAULT);
    end else if (cfg_we) begin
      thr_q  <= thr_in;
      leak_q <= leak_in;
    end
  end

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_cell
    lif_neuron_cell #(
      .WIDTH   (WIDTH),
      .REFRACT (REFRACT)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .cur_i   (cur_in[g*WIDTH +: WIDTH]),
      .thr_i   (thr_q),
      .leak_i  (leak_q),
      .vmem_o  (vmem_w[g]),
      .spike_o (spike_out[g]),
      .fire_o  (fire_w[g]),
      .busy_o  (refr_busy[g])
    );
  end

  // Registered OR of the per-channel next-state pulses, so it lines up with spike_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_any_q <= 1'b0;
    end else begin
      spike_any_q <= |fire_w;
    end
  end

  assign spike_any = spike_any_q;

  // Membrane readout mux; selects past the last channel read as zero.
  always_comb begin
    vmem_out = '0;
    for (int i = 0; i < N_NEURONS; i++) begin
      if (vmem_sel == SEL_W'(i)) vmem_out = vmem_w[i];
    end
  end

endmodule
